ieee_adder_pipe: RTL

//  Pipelined IEEE-754 add/subtract unit, parametrised in exponent/fraction width, with valid/ready flow control.

---
 rtl/ieee_fp_pkg.sv | 19 +
 rtl/ieee_adder_lzc.sv | 20 ++
 rtl/ieee_adder_pipe.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ieee_fp_pkg.sv
// Shared definitions for the pipelined IEEE-754 adder: default field widths,
// guard/round/sticky width and the result-class tag carried down the pipe.
package ieee_fp_pkg;

  localparam int DEF_EXP_W  = 8;
  localparam int DEF_FRAC_W = 23;
  localparam int DEF_TAG_W  = 4;

  // Guard, round and sticky bits kept below the significand LSB.
  localparam int GRS_W = 3;

  // Result class decided in S1, applied when packing in S4.
  typedef enum logic [1:0] {
    RC_NUM = 2'd0,
    RC_INF = 2'd1,
    RC_NAN = 2'd2
  } res_cls_e;

endpackage

// File: rtl/ieee_adder_lzc.sv
// Combinational leading-zero counter. All-zero input returns WIDTH.
module ieee_adder_lzc
  import ieee_fp_pkg::*;
#(
  parameter int WIDTH = DEF_FRAC_W + 1 + GRS_W,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] cnt_o
);

  // Scan LSB to MSB so the highest set bit has the final say.
  always_comb begin
    cnt_o = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/ieee_adder_pipe.sv
// Four-stage IEEE-754 add/subtract with valid/ready flow control.
//   S1 unpack/swap/align, S2 add/sub, S3 normalise, S4 round/pack.
// Define IEEE_ADDER_SPECIALS_EN to give the all-ones exponent Inf/NaN meaning;
// otherwise it is an ordinary finite exponent and overflow saturates.
module ieee_adder_pipe
  import ieee_fp_pkg::*;
#(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [EXP_W+FRAC_W:0]       in_a_i,
  input  logic [EXP_W+FRAC_W:0]       in_b_i,
  input  logic                        in_sub_i,
  input  logic [TAG_W-1:0]            in_tag_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [EXP_W+FRAC_W:0]       out_c_o,
  output logic [TAG_W-1:0]            out_tag_o
);

  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam int SW     = FRAC_W + 1 + GRS_W;   // hidden + fraction + GRS
  localparam int CW     = $clog2(SW + 1);
  localparam int STAGES = 4;

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef struct packed {
    logic               sign;
    logic               eff_sub;
    logic [EXP_W-1:0]   exp;
    logic [SW-1:0]      xm;
    logic [SW-1:0]      ym;
    res_cls_e           cls;
    logic [TAG_W-1:0]   tag;
  } s1_t;

  typedef struct packed {
    logic               sign;
    logic               eff_sub;
    logic [EXP_W-1:0]   exp;
    logic [SW:0]        sum;
    res_cls_e           cls;
    logic [TAG_W-1:0]   tag;
  } s2_t;

  typedef struct packed {
    logic               sign;
    logic [EXP_W:0]     exp;     // one bit of headroom for carry/round overflow
    logic [SW-1:0]      m;
    res_cls_e           cls;
    logic [TAG_W-1:0]   tag;
  } s3_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  logic [W-1:0]     out_c_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [STAGES:1]  vld_q;

  // Stage k loads when empty or when the stage after it loads.
  logic ld_s1, ld_s2, ld_s3, ld_s4;
  assign ld_s4 = !vld_q[4] || out_ready_i;
  assign ld_s3 = !vld_q[3] || ld_s4;
  assign ld_s2 = !vld_q[2] || ld_s3;
  assign ld_s1 = !vld_q[1] || ld_s2;

  assign in_ready_o  = ld_s1;
  assign out_valid_o = vld_q[4];
  assign out_c_o     = out_c_q;
  assign out_tag_o   = out_tag_q;

  // ---------------- S1: unpack, order by magnitude, align ----------------
  logic [W-1:0]     bx, x, y;
  logic [EXP_W-1:0] ex, ey, ex_eff, ey_eff, dexp;
  logic [SW-1:0]    ym_raw, lost_mask;
`ifdef IEEE_ADDER_SPECIALS_EN
  logic x_nan, y_nan, x_inf, y_inf;
`endif

  // Swap so |X| >= |Y|; raw magnitude bits order correctly for finite values.
  always_comb begin
    bx = {in_b_i[W-1] ^ in_sub_i, in_b_i[W-2:0]};
    if (in_a_i[W-2:0] >= bx[W-2:0]) begin
      x = in_a_i;
      y = bx;
    end else begin
      x = bx;
      y = in_a_i;
    end
    ex        = x[W-2:FRAC_W];
    ey        = y[W-2:FRAC_W];
    ex_eff    = (ex == '0) ? EXP_W'(1) : ex;
    ey_eff    = (ey == '0) ? EXP_W'(1) : ey;
    dexp      = ex_eff - ey_eff;
    ym_raw    = {|ey, y[FRAC_W-1:0], {GRS_W{1'b0}}};
    lost_mask = ~({SW{1'b1}} << dexp);

    s1_d         = '0;
    s1_d.sign    = x[W-1];
    s1_d.eff_sub = x[W-1] ^ y[W-1];
    s1_d.exp     = ex_eff;
    s1_d.xm      = {|ex, x[FRAC_W-1:0], {GRS_W{1'b0}}};
    s1_d.tag     = in_tag_i;
    s1_d.cls     = RC_NUM;
    // Far shifts leave only the sticky bit of Y.
    if (32'(dexp) >= 32'(SW - 1))
      s1_d.ym = {{(SW-1){1'b0}}, |ym_raw};
    else
      s1_d.ym = (ym_raw >> dexp) | {{(SW-1){1'b0}}, |(ym_raw & lost_mask)};
`ifdef IEEE_ADDER_SPECIALS_EN
    x_nan = (&ex) && (|x[FRAC_W-1:0]);
    y_nan = (&ey) && (|y[FRAC_W-1:0]);
    x_inf = (&ex) && !(|x[FRAC_W-1:0]);
    y_inf = (&ey) && !(|y[FRAC_W-1:0]);
    // Any infinity sorts into X, so the Inf result takes X's sign.
    if (x_nan || y_nan || (x_inf && y_inf && s1_d.eff_sub))
      s1_d.cls = RC_NAN;
    else if (x_inf || y_inf)
      s1_d.cls = RC_INF;
`endif
  end

  // ---------------- S2: significand add/sub ----------------
  always_comb begin
    s2_d         = '0;
    s2_d.sign    = s1_q.sign;
    s2_d.eff_sub = s1_q.eff_sub;
    s2_d.exp     = s1_q.exp;
    s2_d.cls     = s1_q.cls;
    s2_d.tag     = s1_q.tag;
    if (s1_q.eff_sub)
      s2_d.sum = {1'b0, s1_q.xm} - {1'b0, s1_q.ym};
    else
      s2_d.sum = {1'b0, s1_q.xm} + {1'b0, s1_q.ym};
  end

  // ---------------- S3: normalise ----------------
  logic [CW-1:0]    lz;
  logic [EXP_W-1:0] room;

  ieee_adder_lzc #(.WIDTH(SW), .CNT_W(CW)) u_lzc (
    .data_i (s2_q.sum[SW-1:0]),
    .cnt_o  (lz)
  );

  // Carry shifts right once; cancellation shifts left but never below exp 1,
  // which leaves subnormal results unnormalised.
  always_comb begin
    int sh;
    sh       = 0;
    room     = s2_q.exp - EXP_W'(1);
    s3_d     = '0;
    s3_d.cls = s2_q.cls;
    s3_d.tag = s2_q.tag;
    // Exact zero from a true subtraction is +0; same-sign zeros keep their sign.
    s3_d.sign = (s2_q.sum == '0 && s2_q.eff_sub) ? 1'b0 : s2_q.sign;
    if (s2_q.sum[SW]) begin
      s3_d.m   = {s2_q.sum[SW:2], |s2_q.sum[1:0]};
      s3_d.exp = {1'b0, s2_q.exp} + 1'b1;
    end else begin
      sh       = (int'(lz) > int'(room)) ? int'(room) : int'(lz);
      s3_d.m   = s2_q.sum[SW-1:0] << sh;
      s3_d.exp = {1'b0, s2_q.exp} - (EXP_W+1)'(sh);
    end
  end

  // ---------------- S4: round to nearest even, pack ----------------
  logic               rup;
  logic [FRAC_W+1:0]  rs;
  logic [EXP_W:0]     e_fin;
  logic [FRAC_W-1:0]  frac_fin;
  logic [W-1:0]       res;

  // A rounded significand without the hidden bit packs with exponent field 0.
  always_comb begin
    rup = s3_q.m[2] & (s3_q.m[1] | s3_q.m[0] | s3_q.m[3]);
    rs  = {1'b0, s3_q.m[SW-1:GRS_W]} + (FRAC_W+2)'(rup);
    if (rs[FRAC_W+1]) begin
      e_fin    = s3_q.exp + 1'b1;
      frac_fin = rs[FRAC_W:1];
    end else begin
      e_fin    = rs[FRAC_W] ? s3_q.exp : '0;
      frac_fin = rs[FRAC_W-1:0];
    end
    res = {s3_q.sign, e_fin[EXP_W-1:0], frac_fin};
`ifdef IEEE_ADDER_SPECIALS_EN
    if (e_fin >= {1'b0, EXP_ONES}) res = {s3_q.sign, EXP_ONES, {FRAC_W{1'b0}}};
`else
    if (e_fin > {1'b0, EXP_ONES}) res = {s3_q.sign, EXP_ONES, {FRAC_W{1'b1}}};
`endif
    if (s3_q.cls == RC_NAN)      res = QNAN;
    else if (s3_q.cls == RC_INF) res = {s3_q.sign, EXP_ONES, {FRAC_W{1'b0}}};
  end

  // Stage valid bits advance only where the stage loads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else begin
      if (ld_s1) vld_q[1] <= in_valid_i;
      if (ld_s2) vld_q[2] <= vld_q[1];
      if (ld_s3) vld_q[3] <= vld_q[2];
      if (ld_s4) vld_q[4] <= vld_q[3];
    end
  end

  // Payload registers capture only real operations so bubbles never disturb them.
  always_ff @(posedge clk_i) begin
    if (ld_s1 && in_valid_i) s1_q <= s1_d;
    if (ld_s2 && vld_q[1])   s2_q <= s2_d;
    if (ld_s3 && vld_q[2])   s3_q <= s3_d;
  end

  // Output register holds its value while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_c_q   <= '0;
      out_tag_q <= '0;
    end else if (ld_s4 && vld_q[3]) begin
      out_c_q   <= res;
      out_tag_q <= s3_q.tag;
    end
  end

endmodule
